instr_fetch: RTL and testbench

//   Fetch stage of the unicycle RISC-V core. Holds the PC and runs a req/ack handshake to instruction memory.

---
 rtl/instr_fetch_pkg.sv | 22 ++
 rtl/instr_fetch_if.sv | 26 ++
 rtl/instr_fetch_pc_next.sv | 30 +++
 rtl/instr_fetch.sv | 116 +++++++++++
 tb/tb_instr_fetch.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the fetch stage.
// Optional feature macro: IFETCH_MISALIGN_TRAP_EN.
package ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam int          PC_STEP          = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

`ifdef IFETCH_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory request/acknowledge bus.
// Optional feature macro: IFETCH_MISALIGN_TRAP_EN (not used here).
interface instr_fetch_if #(
    parameter int WIDTH = 32
) ();

    logic             req;
    logic [WIDTH-1:0] addr;
    logic             ack;
    logic [WIDTH-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );

endinterface

// File: rtl/instr_fetch_pc_next.sv
// Next-PC selection: redirect target, sequential step, or hold.
// Optional feature macro: IFETCH_MISALIGN_TRAP_EN (flag consumed by top).
module pc_next
    import ifetch_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] pc,
    input  logic             redirect,
    input  logic [WIDTH-1:0] target,
    input  logic             advance,
    output logic [WIDTH-1:0] next_pc,
    output logic             misaligned
);

    logic [WIDTH-1:0] aligned;

    // Low two bits are dropped so the pc is always word aligned.
    always_comb begin
        aligned    = {target[WIDTH-1:2], 2'b00};
        misaligned = redirect && (target[1:0] != 2'b00);
        next_pc    = pc;
        if (redirect) begin
            next_pc = aligned;
        end else if (advance) begin
            next_pc = pc + WIDTH'(PC_STEP);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: pc register, imem req/ack handshake, instr hand-off.
// Optional feature macro: IFETCH_MISALIGN_TRAP_EN (misalign_err, HALT).
module instr_fetch
    import ifetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [WIDTH-1:0]     redirect_target,
    instr_fetch_if.master        imem,
    output logic [WIDTH-1:0]     instr,
    output logic [WIDTH-1:0]     pc,
`ifdef IFETCH_MISALIGN_TRAP_EN
    output logic                 misalign_err,
`endif
    output logic                 instr_valid
);

    localparam logic [1:0] ST_IDLE  = 2'(IDLE);
    localparam logic [1:0] ST_FETCH = 2'(FETCH);
    localparam logic [1:0] ST_VALID = 2'(VALID);
    localparam logic [1:0] ST_HALT  = 2'(HALT);

    logic [1:0]       state;
    logic             active;
    logic             redir;
    logic             advance;
    logic             mis;
    logic             trap;
    logic [WIDTH-1:0] pc_d;

    // Redirect only counts once the fetch loop is running.
    always_comb begin
        active  = (state == ST_FETCH) || (state == ST_VALID);
        redir   = redirect && active;
        advance = (state == ST_VALID) && !stall;
        trap    = TRAP_EN && mis;
    end

    pc_next #(
        .WIDTH (WIDTH)
    ) u_pc_next (
        .pc         (pc),
        .redirect   (redir),
        .target     (redirect_target),
        .advance    (advance),
        .next_pc    (pc_d),
        .misaligned (mis)
    );

    // Request is a level held for the whole FETCH state.
    always_comb begin
        imem.req  = (state == ST_FETCH);
        imem.addr = pc;
    end

    // FSM and pc/instr registers; redirect beats ack and stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            instr       <= WIDTH'(NOP_INSTR);
            instr_valid <= 1'b0;
        end else if (redir) begin
            instr_valid <= 1'b0;
            if (trap) begin
                state <= ST_HALT;
            end else begin
                state <= ST_FETCH;
                pc    <= pc_d;
            end
        end else begin
            unique case (state)
                ST_IDLE: begin
                    state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (imem.ack) begin
                        instr       <= imem.rdata;
                        instr_valid <= 1'b1;
                        state       <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (advance) begin
                        pc          <= pc_d;
                        instr_valid <= 1'b0;
                        state       <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    instr_valid <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef IFETCH_MISALIGN_TRAP_EN
    // Sticky error flag; cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_err <= 1'b0;
        end else if (redir && trap) begin
            misalign_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed vector bench for instr_fetch.
// Optional feature macro: IFETCH_MISALIGN_TRAP_EN.
module tb_instr_fetch;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] tgt;
        logic        ack;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] instr;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = '0;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_valid;
    logic        err_q;
    int          errors = 0;
    int          checks = 0;
    vec_t        tbl[19];

    instr_fetch_if #(.WIDTH(32)) bus ();

`ifdef IFETCH_MISALIGN_TRAP_EN
    logic misalign_err;
    assign err_q = misalign_err;
`else
    assign err_q = 1'b0;
`endif

    instr_fetch #(
        .WIDTH    (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem            (bus.master),
        .instr           (instr),
        .pc              (pc),
`ifdef IFETCH_MISALIGN_TRAP_EN
        .misalign_err    (misalign_err),
`endif
        .instr_valid     (instr_valid)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        logic st, logic rd, logic [31:0] tg, logic ak, logic [31:0] rdt,
        logic rq, logic [31:0] ad, logic vl, logic [31:0] ins, logic er
    );
        vec_t v;
        v.stall = st; v.redir = rd; v.tgt = tg;
        v.ack = ak; v.rdata = rdt;
        v.req = rq; v.addr = ad; v.vld = vl;
        v.instr = ins; v.err = er;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all(string tag, logic rq, logic [31:0] ad,
                           logic vl, logic [31:0] ins, logic er);
        chk({tag, ".req"}, 32'(bus.req), 32'(rq));
        chk({tag, ".addr"}, bus.addr, ad);
        chk({tag, ".pc"}, pc, ad);
        chk({tag, ".valid"}, 32'(instr_valid), 32'(vl));
        chk({tag, ".instr"}, instr, ins);
`ifdef IFETCH_MISALIGN_TRAP_EN
        chk({tag, ".err"}, 32'(err_q), 32'(er));
`else
        if (er !== err_q) chk({tag, ".err"}, 32'(err_q), 32'(er));
`endif
    endtask

    initial begin
        bus.ack   = 1'b0;
        bus.rdata = '0;

        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h13, 0);
        tbl[1]  = mk(0, 0, 0, 1, 32'h00500093, 1, 0, 0, 32'h13, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h00500093, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 1, 4, 0, 32'h00500093, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 1, 4, 0, 32'h00500093, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 1, 4, 0, 32'h00500093, 0);
        tbl[6]  = mk(0, 0, 0, 1, 32'h11111111, 1, 4, 0, 32'h00500093, 0);
        tbl[7]  = mk(1, 0, 0, 0, 0, 0, 4, 1, 32'h11111111, 0);
        tbl[8]  = mk(1, 0, 0, 0, 0, 0, 4, 1, 32'h11111111, 0);
        tbl[9]  = mk(1, 0, 0, 0, 0, 0, 4, 1, 32'h11111111, 0);
        tbl[10] = mk(1, 0, 0, 0, 0, 0, 4, 1, 32'h11111111, 0);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 4, 1, 32'h11111111, 0);
        tbl[12] = mk(0, 1, 32'h100, 1, 32'hDEADBEEF, 1, 8, 0, 32'h11111111, 0);
        tbl[13] = mk(0, 0, 0, 1, 32'h22222222, 1, 32'h100, 0, 32'h11111111, 0);
        tbl[14] = mk(1, 1, 32'hFFFFFFFC, 0, 0, 0, 32'h100, 1, 32'h22222222, 0);
        tbl[15] = mk(0, 0, 0, 1, 32'h33333333, 1, 32'hFFFFFFFC, 0, 32'h22222222, 0);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 32'hFFFFFFFC, 1, 32'h33333333, 0);
        tbl[17] = mk(0, 1, 32'h102, 0, 0, 1, 0, 0, 32'h33333333, 0);
`ifdef IFETCH_MISALIGN_TRAP_EN
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h33333333, 1);
`else
        tbl[18] = mk(0, 0, 0, 0, 0, 1, 32'h100, 0, 32'h33333333, 0);
`endif

        // Reset held for two edges, checked while asserted.
        @(negedge clk);
        tick();
        chk_all("reset", 0, 0, 0, 32'h13, 0);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            stall           = tbl[i].stall;
            redirect        = tbl[i].redir;
            redirect_target = tbl[i].tgt;
            bus.ack         = tbl[i].ack;
            bus.rdata       = tbl[i].rdata;
            #1;
            chk_all($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr,
                    tbl[i].vld, tbl[i].instr, tbl[i].err);
            tick();
        end

`ifdef IFETCH_MISALIGN_TRAP_EN
        // HALT ignores redirect and stall until reset.
        for (int i = 0; i < 3; i++) begin
            stall           = 1'b1;
            redirect        = 1'b1;
            redirect_target = 32'h200;
            tick();
            chk_all($sformatf("halt%0d", i), 0, 0, 0, 32'h33333333, 1);
        end
`else
        // Fetch at 0x100 still waiting; a late ack completes it.
        bus.ack   = 1'b1;
        bus.rdata = 32'h66666666;
        tick();
        chk_all("late_ack", 0, 32'h100, 1, 32'h66666666, 0);
`endif

        // Reset, then redirect during IDLE must be ignored.
        stall    = 1'b0;
        redirect = 1'b0;
        bus.ack  = 1'b0;
        rst      = 1'b1;
        tick();
        rst             = 1'b0;
        redirect        = 1'b1;
        redirect_target = 32'h300;
        #1;
        chk_all("idle", 0, 0, 0, 32'h13, 0);
        tick();
        redirect = 1'b0;
        chk_all("idle_redir", 1, 0, 0, 32'h13, 0);

        // Reset in the middle of a handshake drops the ack.
        rst       = 1'b1;
        bus.ack   = 1'b1;
        bus.rdata = 32'h55555555;
        tick();
        chk_all("rst_mid", 0, 0, 0, 32'h13, 0);
        rst     = 1'b0;
        bus.ack = 1'b0;
        tick();
        chk_all("after_rst", 1, 0, 0, 32'h13, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
